uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, meaning the number of requesters (fixed at 4 for this revision).
REQ-002 The module SHALL have parameter TIMEOUT, default 16, meaning the cycles allowed between tx_start and tx_busy rising.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, which is the divided baud-domain clock shared with Rx/Tx.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port req, input, 4 bits: per-requester send request, level, one bit per requester.
REQ-006 The module SHALL have port data_in, input, 32 bits: requester i byte on bits [8i+7:8i].
REQ-007 The module SHALL have port tx_busy, input, 1 bit: high while the Tx serializer shifts a frame.
REQ-008 The module SHALL have port err_clr, input, 1 bit: clears err.
REQ-009 The module SHALL have port grant, output, 4 bits: one-hot, one-cycle pulse telling requester i its byte was taken.
REQ-010 The module SHALL have port tx_data, output, 8 bits: byte presented to Tx.
REQ-011 The module SHALL have port tx_start, output, 1 bit: one-cycle start pulse to Tx.
REQ-012 The module SHALL have port owner, output, 2 bits: index of the current or last granted requester.
REQ-013 The module SHALL have port active, output, 1 bit: high in every state except IDLE.
REQ-014 The module SHALL have port err, output, 1 bit: sticky flag set when Tx failed to go busy.

Function
REQ-015 The FSM SHALL have the states IDLE, START, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-016 The FSM SHALL sample req only in IDLE; in IDLE with req!=0 and tx_busy==0 it SHALL pick sel with round-robin priority, searching from (last+1) mod 4 upward with wrap, where last is the previously granted index.
REQ-017 On the pick edge the FSM SHALL register tx_data=data_in[sel], owner=sel and last=sel, and move to START.
REQ-018 In START, grant[sel] and tx_start SHALL be high for exactly this one cycle; latency from the req-sampling edge to the grant/tx_start cycle is 1 clock. START SHALL then move to WAIT_BUSY.
REQ-019 WAIT_BUSY: when tx_busy==1 the FSM SHALL go to WAIT_DONE. If tx_busy has not been seen within TIMEOUT cycles of entering WAIT_BUSY, the FSM SHALL set err=1 and return to IDLE; the counter SHALL be 5 bits and saturate, never wrap.
REQ-020 WAIT_DONE: when tx_busy==0 the FSM SHALL return to IDLE; there is no timeout in this state.
REQ-021 IDLE with tx_busy==1 (foreign or stale frame) SHALL NOT grant; the FSM holds until tx_busy==0.
REQ-022 A requester SHALL drop req in the cycle after its grant; a req still high when the FSM re-enters IDLE SHALL be treated as a new request, with round-robin giving other requesters priority first.
REQ-023 tx_data SHALL hold its value until the next pick; owner SHALL hold its value after return to IDLE.
REQ-024 err SHALL be sticky; err_clr SHALL clear it; on simultaneous set and err_clr, set SHALL win.
REQ-025 Back-to-back throughput SHALL be one byte per frame time plus 2 cycles (the IDLE and START states).

Reset
REQ-026 On reset=1 at a clk edge, the block SHALL go to state IDLE with grant=0, tx_start=0, tx_data=8'h00, owner=0, active=0, err=0, last=3 (so requester 0 wins first), and the timeout counter cleared.
REQ-027 Reset mid-frame SHALL abort without issuing any further tx_start or grant; behaviour of Tx itself is Tx's own reset responsibility.

Structure
REQ-028 Package uart_arb_pkg SHALL hold the FSM state enum and the constants NREQ_DEF=4, TIMEOUT_DEF=16 and BYTE_W=8.
REQ-029 The round-robin search SHALL be a combinational sub-module rr_pick with inputs req[3:0] and last[1:0], and outputs sel[1:0] and any.
REQ-030 All state SHALL be held in one clocked process, with no latches.

Verification
REQ-031 Bench case, reset release: apply req=4'b0001 with byte 8'h55 and model tx_busy 2 cycles after tx_start for 10 cycles. Required: grant=0001 and tx_start in the same single cycle, tx_data=8'h55, err=0.
REQ-032 Bench case, contention: hold req=4'b1111 with bytes A0..A3. Required: grant order 0,1,2,3,0; each grant is separated by at least one full tx_busy period.
REQ-033 Bench case, timeout: apply req=4'b0100 and keep tx_busy low. Required: err=1 exactly TIMEOUT cycles after WAIT_BUSY entry, then IDLE; err_clr returns err to 0.
REQ-034 Bench case, busy blocking: hold tx_busy=1 in IDLE with req=4'b0010. Required: no grant until tx_busy falls, then grant=0010 one cycle later.
REQ-035 Bench case, reset mid-operation: assert reset during WAIT_DONE. Required: next cycle all outputs at reset values; after release, last=3 so requester 0 is served before requester 1 when both request.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } arb_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first active request at or after (last+1) mod 4, with wrap.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] sel,
  output logic       any
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the nearest requester after last wins.
  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    any = |req;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (req[idx]) sel = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates four byte requesters onto one UART Tx serializer with
// round-robin priority and a busy-handshake timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BYTE_W-1:0] data_in,
  input  logic                   tx_busy,
  input  logic                   err_clr,
  output logic [NREQ-1:0]        grant,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_start,
  output logic [1:0]             owner,
  output logic                   active,
  output logic                   err
);

  localparam logic [4:0] TO_LIM = 5'(TIMEOUT - 1);

  arb_state_t        state_q;
  logic [NREQ-1:0]   grant_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic [1:0]        owner_q;
  logic [1:0]        last_q;
  logic              active_q;
  logic              err_q;
  logic [4:0]        cnt_q;

  logic [4:0]        cnt_d;
  logic [1:0]        sel_d;
  logic              any_d;
  logic [BYTE_W-1:0] pick_byte_d;

  rr_pick u_rr_pick (
    .req  (req),
    .last (last_q),
    .sel  (sel_d),
    .any  (any_d)
  );

  assign pick_byte_d = data_in[{sel_d, 3'b000} +: BYTE_W];
  assign cnt_d       = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      owner_q    <= 2'd0;
      last_q     <= 2'd3;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 5'd0;
    end else begin
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      // A timeout set below overrides this clear in the same cycle.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_d && !tx_busy) begin
            tx_data_q  <= pick_byte_d;
            owner_q    <= sel_d;
            last_q     <= sel_d;
            grant_q    <= onehot4(sel_d);
            tx_start_q <= 1'b1;
            active_q   <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          cnt_q   <= 5'd0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q >= TO_LIM) begin
            err_q    <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign owner    = owner_q;
  assign active   = active_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written corner sequences.
module tb_uart_tx_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        tx_busy;
  logic        err_clr;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [1:0]  owner;
  logic        active;
  logic        err;

  logic        model_en;
  logic        busy_man;
  int          mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
    .tx_busy  (tx_busy),
    .err_clr  (err_clr),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .owner    (owner),
    .active   (active),
    .err      (err)
  );

  // Tx model: busy rises two cycles after the tx_start cycle and lasts ten cycles.
  always @(posedge clk) begin
    if (reset) mcnt <= 0;
    else if (tx_start) mcnt <= 1;
    else if (mcnt > 0 && mcnt < 11) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  assign tx_busy = model_en ? (mcnt >= 2) : busy_man;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output logic ok, output int busy_cyc);
    ok = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_busy) busy_cyc++;
      if (grant != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   bc;
    logic quiet;

    vecs[0] = '{4'b0001, 32'h0000_0055, 4'b0001, 8'h55, 2'd0};
    vecs[1] = '{4'b0011, 32'h0000_2211, 4'b0010, 8'h22, 2'd1};
    vecs[2] = '{4'b0011, 32'h0000_4433, 4'b0001, 8'h33, 2'd0};
    vecs[3] = '{4'b1000, 32'hC300_0000, 4'b1000, 8'hC3, 2'd3};
    vecs[4] = '{4'b0110, 32'h0066_7700, 4'b0010, 8'h77, 2'd1};
    vecs[5] = '{4'b0101, 32'h0088_0099, 4'b0100, 8'h88, 2'd2};
    vecs[6] = '{4'b1001, 32'hBB00_00AA, 4'b1000, 8'hBB, 2'd3};
    vecs[7] = '{4'b1111, 32'hD4D3_D2D1, 4'b0001, 8'hD1, 2'd0};

    req = 4'b0; data_in = 32'h0; err_clr = 1'b0;
    model_en = 1'b1; busy_man = 1'b0;
    do_reset();

    chk("rst_grant",    32'(grant),    32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data",  32'(tx_data),  32'h0);
    chk("rst_owner",    32'(owner),    32'h0);
    chk("rst_active",   32'(active),   32'h0);
    chk("rst_err",      32'(err),      32'h0);

    // Table: round-robin picks with the Tx model answering each start.
    for (int v = 0; v < 8; v++) begin
      req = vecs[v].req;
      data_in = vecs[v].data;
      wait_grant(40, ok, bc);
      chk("vec_grant_seen", 32'(ok), 32'h1);
      chk("vec_grant",    32'(grant),    32'(vecs[v].exp_grant));
      chk("vec_tx_start", 32'(tx_start), 32'h1);
      chk("vec_tx_data",  32'(tx_data),  32'(vecs[v].exp_data));
      chk("vec_owner",    32'(owner),    32'(vecs[v].exp_owner));
      chk("vec_active",   32'(active),   32'h1);
      chk("vec_err",      32'(err),      32'h0);
      $display("[TB] vec %0d req=%b grant=%b tx_data=%0h owner=%0d", v, req, grant, tx_data, owner);
      req = 4'b0;
      data_in = 32'hFFFF_FFFF;
      tick();
      chk("vec_start_pulse", {28'h0, grant}, {31'h0, tx_start});
      chk("vec_start_once",  32'(tx_start), 32'h0);
      wait_idle(40, ok);
      chk("vec_idle_seen",  32'(ok),      32'h1);
      chk("vec_hold_data",  32'(tx_data), 32'(vecs[v].exp_data));
      chk("vec_hold_owner", 32'(owner),   32'(vecs[v].exp_owner));
    end

    // Contention: all four requesters held high.
    do_reset();
    req = 4'b1111;
    data_in = 32'hA3A2_A1A0;
    for (int g = 0; g < 5; g++) begin
      logic [1:0] exp_i;
      exp_i = 2'(g % 4);
      wait_grant(60, ok, bc);
      chk("cont_grant_seen", 32'(ok), 32'h1);
      chk("cont_grant",   32'(grant),   32'(4'b0001 << exp_i));
      chk("cont_tx_data", 32'(tx_data), 32'h0000_00A0 + 32'(exp_i));
      if (g > 0) chk("cont_gap_busy", 32'(bc >= 10), 32'h1);
      $display("[TB] contention grant %0d: grant=%b tx_data=%0h busy_cycles=%0d", g, grant, tx_data, bc);
    end
    req = 4'b0;
    wait_idle(40, ok);

    // Timeout: Tx never goes busy.
    do_reset();
    model_en = 1'b0;
    busy_man = 1'b0;
    req = 4'b0100;
    data_in = 32'h0077_0000;
    wait_grant(10, ok, bc);
    chk("to_grant", 32'(grant), 32'h4);
    req = 4'b0;
    tick();
    quiet = 1'b1;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (err || !active) quiet = 1'b0;
    end
    chk("to_no_early_err", 32'(quiet),  32'h1);
    tick();
    chk("to_err_set",      32'(err),    32'h1);
    chk("to_back_idle",    32'(active), 32'h0);
    $display("[TB] timeout: err=%0d active=%0d after %0d cycles in WAIT_BUSY", err, active, TO);
    tick(); tick(); tick();
    chk("to_err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err), 32'h0);

    // Second timeout with err_clr held: the set must win.
    err_clr = 1'b1;
    req = 4'b0100;
    wait_grant(10, ok, bc);
    chk("to2_grant", 32'(grant), 32'h4);
    req = 4'b0;
    wait_idle(40, ok);
    chk("to2_idle_seen", 32'(ok),  32'h1);
    chk("to2_set_wins",  32'(err), 32'h1);
    err_clr = 1'b0;
    tick();
    chk("to2_err_held", 32'(err), 32'h1);
    $display("[TB] timeout with err_clr: err=%0d", err);

    // Busy blocking in IDLE.
    do_reset();
    busy_man = 1'b1;
    req = 4'b0010;
    data_in = 32'h0000_3C00;
    quiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (grant != 4'b0 || active) quiet = 1'b0;
    end
    chk("blk_no_grant", 32'(quiet), 32'h1);
    busy_man = 1'b0;
    tick();
    chk("blk_grant",    32'(grant),    32'h2);
    chk("blk_tx_start", 32'(tx_start), 32'h1);
    chk("blk_tx_data",  32'(tx_data),  32'h3C);
    $display("[TB] busy blocking: grant=%b one cycle after busy fell", grant);
    req = 4'b0;
    busy_man = 1'b1;
    wait_idle(40, ok);
    busy_man = 1'b0;
    tick();

    // Reset during WAIT_DONE, then check last pointer went back to 3.
    do_reset();
    model_en = 1'b1;
    req = 4'b0001;
    data_in = 32'h0000_0011;
    wait_grant(10, ok, bc);
    chk("mid_grant0", 32'(grant), 32'h1);
    req = 4'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx_busy && active) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_busy_seen", 32'(ok), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_grant",    32'(grant),    32'h0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'h0);
    chk("mid_rst_tx_data",  32'(tx_data),  32'h0);
    chk("mid_rst_owner",    32'(owner),    32'h0);
    chk("mid_rst_active",   32'(active),   32'h0);
    chk("mid_rst_err",      32'(err),      32'h0);
    reset = 1'b0;
    req = 4'b0011;
    data_in = 32'h0000_2211;
    wait_grant(10, ok, bc);
    chk("mid_after_grant", 32'(grant),   32'h1);
    chk("mid_after_data",  32'(tx_data), 32'h11);
    $display("[TB] reset mid-frame: first grant after release=%b", grant);
    req = 4'b0;
    wait_idle(40, ok);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
